// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the matrix calculator front end.
//   loader_state_t : phases of the operand loader (fill A, fill B, hold)
//   op_t           : 2-bit operation select carried alongside the operands
//   INDEX_W        : width of the element index bus
//   MAX_ELEMS      : largest element count an index of INDEX_W can address
//   last_index()   : index of the final element of a DIM x DIM matrix
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int INDEX_W   = 4;
  localparam int MAX_ELEMS = 16;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } loader_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AUX = 2'd3
  } op_t;

  // Elements are numbered row-major from 0, so the final one is DIM*DIM-1.
  function automatic logic [INDEX_W-1:0] last_index(input int dim);
    return INDEX_W'(dim * dim - 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Level debouncer for an already-synchronized push button.
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   raw        : synchronized but bouncy button level
//   stable     : debounced level, flips only after DEB_CYCLES agreeing samples
//   rise_pulse : registered one-cycle pulse the cycle after stable rises
// A level change is accepted only once raw has disagreed with stable for
// DEB_CYCLES consecutive samples; any agreeing sample restarts the count, so
// bounces shorter than that never reach the stable level.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise_pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      stable     <= 1'b0;
      stable_d   <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      stable_d   <= stable;
      // Edge detect on the previous-cycle stable level so the pulse lands
      // on the cycle after the rise and lasts exactly one cycle.
      rise_pulse <= stable & ~stable_d;

      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_entry_loader.sv
// -----------------------------------------------------------------------------
// matrix_entry_loader
// Turns debounced presses of the enter button into element writes, filling
// operand matrix A and then matrix B in row-major order, and hands the pair
// plus the latched operation to the calculator core over valid/ready.
//   clk            : system clock (25 MHz)
//   rst            : asynchronous, active-low reset
//   data_in        : synchronized element value, captured on an accepted press
//   enter          : synchronized, bouncy enter button
//   operation      : synchronized operation select, latched with B's last element
//   operands_ready : core accepts the presented operands
//   mat_a, mat_b   : operand matrices, element k at [k*WIDTH +: WIDTH]
//   op_out         : operation latched with the last element of B
//   operands_valid : mat_a/mat_b/op_out are complete and frozen
//   index          : index of the next element to be written
//   loading_b      : high while filling B or holding operands
//   enter_ack      : one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module matrix_entry_loader
  import calc_pkg::*;
#(
  parameter int DIM        = 2,
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enter,
  input  logic [1:0]                 operation,
  input  logic                       operands_ready,
  output logic [DIM*DIM*WIDTH-1:0]   mat_a,
  output logic [DIM*DIM*WIDTH-1:0]   mat_b,
  output logic [1:0]                 op_out,
  output logic                       operands_valid,
  output logic [INDEX_W-1:0]         index,
  output logic                       loading_b,
  output logic                       enter_ack
);

  localparam logic [INDEX_W-1:0] LAST_IDX = last_index(DIM);

  loader_state_t state;
  op_t           op_q;
  logic          enter_stable;
  logic          accept;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_enter_deb (
    .clk        (clk),
    .rst        (rst),
    .raw        (enter),
    .stable     (enter_stable),
    .rise_pulse (accept)
  );

  // The accept pulse is already a register, so it doubles as the ack output
  // and is exactly aligned with the write it triggers.
  assign enter_ack = accept;
  assign op_out    = op_q;

  // An accept can only follow a cycle in which the debounced level was high.
  accept_follows_stable: assert property (
    @(posedge clk) disable iff (!rst) accept |-> $past(enter_stable)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= LOAD_A;
      mat_a          <= '0;
      mat_b          <= '0;
      op_q           <= OP_ADD;
      operands_valid <= 1'b0;
      index          <= '0;
      loading_b      <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            mat_a[int'(index)*WIDTH +: WIDTH] <= data_in;
            if (index == LAST_IDX) begin
              index     <= '0;
              loading_b <= 1'b1;
              state     <= LOAD_B;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        LOAD_B: begin
          if (accept) begin
            mat_b[int'(index)*WIDTH +: WIDTH] <= data_in;
            if (index == LAST_IDX) begin
              op_q           <= op_t'(operation);
              index          <= '0;
              operands_valid <= 1'b1;
              state          <= HOLD;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        HOLD: begin
          // Operands stay frozen; presses are acknowledged but not stored.
          // A press coinciding with the handshake is dropped as well, so the
          // next press after release lands in A[0].
          if (operands_valid && operands_ready) begin
            operands_valid <= 1'b0;
            loading_b      <= 1'b0;
            index          <= '0;
            state          <= LOAD_A;
          end
        end

        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_entry_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_entry_loader
// Directed bench for matrix_entry_loader with DIM=2, WIDTH=8, DEB_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_matrix_entry_loader;

  localparam int DIM        = 2;
  localparam int WIDTH      = 8;
  localparam int DEB_CYCLES = 4;
  localparam int MW         = DIM * DIM * WIDTH;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  data_in;
  logic              enter;
  logic [1:0]        operation;
  logic              operands_ready;
  logic [MW-1:0]     mat_a;
  logic [MW-1:0]     mat_b;
  logic [1:0]        op_out;
  logic              operands_valid;
  logic [3:0]        index;
  logic              loading_b;
  logic              enter_ack;

  int checks   = 0;
  int failures = 0;

  matrix_entry_loader #(
    .DIM        (DIM),
    .WIDTH      (WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .enter          (enter),
    .operation      (operation),
    .operands_ready (operands_ready),
    .mat_a          (mat_a),
    .mat_b          (mat_b),
    .op_out         (op_out),
    .operands_valid (operands_valid),
    .index          (index),
    .loading_b      (loading_b),
    .enter_ack      (enter_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clean press: hold enter until the ack (bounded), optionally raise
  // operands_ready on the ack cycle, then release long enough to debounce low.
  task automatic press(input logic [WIDTH-1:0] d, input bit hs_on_ack);
    int lat;
    @(negedge clk);
    data_in = d;
    enter   = 1'b1;
    lat     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (enter_ack) begin
        lat = i;
        break;
      end
    end
    check("ack_latency", 64'(lat), 64'(DEB_CYCLES + 1));
    if (hs_on_ack) operands_ready = 1'b1;
    @(negedge clk);
    operands_ready = 1'b0;
    check("ack_width", 64'(enter_ack), 64'd0);
    enter = 1'b0;
    repeat (DEB_CYCLES + 3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mat_a"}, 64'(mat_a), 64'd0);
    check({tag, "_mat_b"}, 64'(mat_b), 64'd0);
    check({tag, "_op_out"}, 64'(op_out), 64'd0);
    check({tag, "_valid"}, 64'(operands_valid), 64'd0);
    check({tag, "_index"}, 64'(index), 64'd0);
    check({tag, "_loading_b"}, 64'(loading_b), 64'd0);
    check({tag, "_enter_ack"}, 64'(enter_ack), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_ack;
    logic [7:0] idx_exp [4];
    logic [7:0] a_vals  [4];
    logic [7:0] b_vals  [4];
    a_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_vals  = '{8'h05, 8'h06, 8'h07, 8'h08};
    idx_exp = '{8'd1, 8'd2, 8'd3, 8'd0};

    rst            = 1'b0;
    enter          = 1'b0;
    data_in        = '0;
    operation      = 2'b00;
    operands_ready = 1'b0;
    #1;
    check_all_zero("reset");
    #20 rst = 1'b1;

    // Bounce rejection: 2-cycle pulses never reach the 4-cycle threshold.
    seen_ack = 1'b0;
    data_in  = 8'h5C;
    for (int p = 0; p < 4; p++) begin
      enter = (p % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        seen_ack |= enter_ack;
      end
    end
    enter = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_ack |= enter_ack;
    end
    check("bounce_ack", 64'(seen_ack), 64'd0);
    check("bounce_index", 64'(index), 64'd0);
    check("bounce_mat_a", 64'(mat_a), 64'd0);

    // Clean load of A.
    for (int k = 0; k < 4; k++) begin
      press(a_vals[k], 1'b0);
      check("loadA_index", 64'(index), 64'(idx_exp[k]));
      check("loadA_loading_b", 64'(loading_b), (k == 3) ? 64'd1 : 64'd0);
    end
    check("loadA_mat_a", 64'(mat_a), 64'h44332211);
    check("loadA_valid", 64'(operands_valid), 64'd0);

    // Fill B; operation latched with the last element.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) operation = 2'b10;
      press(b_vals[k], 1'b0);
      check("loadB_index", 64'(index), 64'(idx_exp[k]));
      check("loadB_valid", 64'(operands_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    check("hold_mat_b", 64'(mat_b), 64'h08070605);
    check("hold_op_out", 64'(op_out), 64'd2);
    check("hold_loading_b", 64'(loading_b), 64'd1);

    // Presses in HOLD change nothing.
    operation = 2'b01;
    press(8'h99, 1'b0);
    press(8'h98, 1'b0);
    check("hold_frozen_a", 64'(mat_a), 64'h44332211);
    check("hold_frozen_b", 64'(mat_b), 64'h08070605);
    check("hold_frozen_op", 64'(op_out), 64'd2);
    check("hold_frozen_valid", 64'(operands_valid), 64'd1);
    check("hold_frozen_index", 64'(index), 64'd0);

    // Handshake.
    @(negedge clk);
    operands_ready = 1'b1;
    @(negedge clk);
    operands_ready = 1'b0;
    check("hs_valid", 64'(operands_valid), 64'd0);
    check("hs_index", 64'(index), 64'd0);
    check("hs_loading_b", 64'(loading_b), 64'd0);
    press(8'hAA, 1'b0);
    check("hs_next_mat_a", 64'(mat_a), 64'h443322AA);
    check("hs_next_mat_b", 64'(mat_b), 64'h08070605);
    check("hs_next_index", 64'(index), 64'd1);

    // Async reset after three elements of B.
    press(8'h12, 1'b0);
    press(8'h13, 1'b0);
    press(8'h14, 1'b0);
    check("mid_mat_a", 64'(mat_a), 64'h141312AA);
    press(8'h21, 1'b0);
    press(8'h22, 1'b0);
    press(8'h23, 1'b0);
    check("mid_index", 64'(index), 64'd3);
    check("mid_loading_b", 64'(loading_b), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    press(8'h5A, 1'b0);
    check("post_rst_mat_a", 64'(mat_a), 64'h0000005A);
    check("post_rst_mat_b", 64'(mat_b), 64'd0);
    check("post_rst_index", 64'(index), 64'd1);
    check("post_rst_loading_b", 64'(loading_b), 64'd0);

    // Accept/handshake collision in HOLD.
    press(8'h61, 1'b0);
    press(8'h62, 1'b0);
    press(8'h63, 1'b0);
    operation = 2'b11;
    press(8'h71, 1'b0);
    press(8'h72, 1'b0);
    press(8'h73, 1'b0);
    press(8'h74, 1'b0);
    check("col_pre_valid", 64'(operands_valid), 64'd1);
    check("col_pre_op", 64'(op_out), 64'd3);
    press(8'hEE, 1'b1);
    check("col_valid", 64'(operands_valid), 64'd0);
    check("col_index", 64'(index), 64'd0);
    check("col_loading_b", 64'(loading_b), 64'd0);
    check("col_mat_a", 64'(mat_a), 64'h6362615A);
    check("col_mat_b", 64'(mat_b), 64'h74737271);
    press(8'h0F, 1'b0);
    check("col_next_mat_a", 64'(mat_a), 64'h6362610F);
    check("col_next_index", 64'(index), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_entry_loader.md
Name: matrix_entry_loader

Overview:
- Sits between the input synchronizers and the calculator core.
- Debounces the synchronized enter line and turns each clean press into one element write.
- Fills operand matrix A, then matrix B, element by element (row-major), and drives the element index shown on the index pins.
- When both matrices are full, presents them with the latched operation to the core over a valid/ready handshake.

Parameters:
DIM, 2, square matrix dimension; DIM*DIM <= 16
WIDTH, 8, element width in bits
DEB_CYCLES, 250000, consecutive stable cycles needed to accept a level change on enter (10 ms at 25 MHz)

Ports:
clk  in  1  system clock, 25 MHz
rst  in  1  asynchronous, active-low reset
data_in  in  WIDTH  synchronized element value
enter  in  1  synchronized raw enter button (bouncy)
operation  in  2  synchronized operation select
operands_ready  in  1  core accepts operands
mat_a  out  DIM*DIM*WIDTH  matrix A, element k at bits [k*WIDTH +: WIDTH]
mat_b  out  DIM*DIM*WIDTH  matrix B, same packing
op_out  out  2  operation latched with last element of B
operands_valid  out  1  mat_a/mat_b/op_out are complete and stable
index  out  4  index of next element to be written (0..DIM*DIM-1)
loading_b  out  1  1 while filling B or holding operands
enter_ack  out  1  one-cycle pulse per accepted element

Behaviour:
- rst low (any time, asynchronous): all outputs 0; state LOAD_A; debounce counter 0; stable enter level 0.
- Reset mid-load discards partial matrices.
- Debounce:
  - The counter increments while raw enter differs from the stable level, and clears when they match.
  - When the counter reaches DEB_CYCLES-1 and raw still differs, the stable level flips and the counter clears.
  - Bounces shorter than DEB_CYCLES are invisible.
- Accept pulse: registered, asserted for exactly 1 cycle on the cycle after the stable level rises 0->1. Release is not an event. enter_ack equals the accept pulse.
- Latency: raw enter held high -> enter_ack high DEB_CYCLES+1 cycles after the first high sample.
- State machine:
  - LOAD_A:
    - On accept, write data_in to mat_a[index].
    - If index < DIM*DIM-1, index++.
    - Else index <- 0, loading_b <- 1, go LOAD_B.
  - LOAD_B:
    - On accept, write data_in to mat_b[index].
    - On the last element, also latch op_out <- operation, index <- 0, operands_valid <- 1, go HOLD.
  - HOLD:
    - operands_valid = 1.
    - mat_a, mat_b and op_out are frozen.
    - Accepts are ignored (no write, but enter_ack still pulses).
    - On operands_valid & operands_ready at a clock edge: operands_valid <- 0, loading_b <- 0, go LOAD_A, index 0.
    - Matrix contents are retained until overwritten.
- operands_valid never drops without handshake completion, except on reset.
- Data is sampled on the accept-cycle edge. data_in changing during bounce is irrelevant.
- index always < DIM*DIM. Wrap from DIM*DIM-1 to 0 occurs only at the A->B and B->HOLD transitions.
- Simultaneous accept and handshake in HOLD: the handshake wins, the accept is dropped, and the next press writes element A[0].
- Elements are stored unmodified. There is no arithmetic or sign interpretation.

Decomposition:
- Shared package (calc_pkg):
  - loader_state_t enum {LOAD_A, LOAD_B, HOLD}
  - op_t (2-bit operation encoding)
  - INDEX_W = 4
  - MAX_ELEMS = 16
- Sub-module btn_debounce:
  - Parameter DEB_CYCLES; ports clk, rst, raw, stable, rise_pulse.
  - Reused later for the sw and operation buttons.

Test Plan (DEB_CYCLES=4, DIM=2):
1. Bounce rejection: toggle enter 1,0,1,0 with 2-cycle pulses, then hold low -> no enter_ack, index stays 0, mat_a = 0.
2. Clean load: four clean presses with data_in = 8'h11, 22, 33, 44 -> mat_a = 32'h44332211; loading_b rises after the 4th; index sequence 1,2,3,0.
3. Full cycle: continue with presses 8'h05, 06, 07, 08 and operation=2'b10, operands_ready=0 -> operands_valid=1, mat_b = 32'h08070605, op_out=2'b10. Further presses leave all three unchanged.
4. Handshake: raise operands_ready for 1 cycle -> operands_valid falls next cycle, index 0, loading_b 0. The next press with 8'hAA writes only mat_a[7:0].
5. Async reset mid-load: after 3 elements of B, pulse rst low between clock edges -> all outputs 0 immediately, without waiting for a clock edge; state LOAD_A.
6. Accept/handshake collision: in HOLD, time operands_ready=1 on the enter_ack cycle -> returns to LOAD_A, mat_a unchanged, index 0.
